// File: rtl/vga_timing_generator.sv
// Parametrised raster timing generator: position, syncs, blanking, look-ahead fetch position,
// line/frame events and a latched vertical-blank interrupt. All outputs are registered together.
module vga_timing_generator #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned PREFETCH = 2,
  parameter int unsigned H_BITS   = 10,
  parameter int unsigned V_BITS   = 10
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              irq_ack,
  output logic [H_BITS-1:0] cycle,
  output logic [V_BITS-1:0] scanline,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank,
  output logic [H_BITS-1:0] fetch_cycle,
  output logic [V_BITS-1:0] fetch_scanline,
  output logic              fetch_active,
  output logic              line_start,
  output logic              frame_start,
  output logic [7:0]        frame_count,
  output logic              vblank_irq
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [H_BITS-1:0] HLast      = H_BITS'(H_TOTAL - 1);
  localparam logic [H_BITS-1:0] HActive    = H_BITS'(H_ACTIVE);
  localparam logic [H_BITS-1:0] HSyncFirst = H_BITS'(H_ACTIVE + H_FRONT);
  localparam logic [H_BITS-1:0] HSyncLast  = H_BITS'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [V_BITS-1:0] VLast      = V_BITS'(V_TOTAL - 1);
  localparam logic [V_BITS-1:0] VActive    = V_BITS'(V_ACTIVE);
  localparam logic [V_BITS-1:0] VSyncFirst = V_BITS'(V_ACTIVE + V_FRONT);
  localparam logic [V_BITS-1:0] VSyncLast  = V_BITS'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  // PREFETCH < H_TOTAL, so the reset fetch position never leaves line 0.
  localparam logic [H_BITS-1:0] FetchRstCycle  = H_BITS'(PREFETCH);
  localparam bit                FetchRstActive = (PREFETCH < H_ACTIVE) && (V_ACTIVE > 0);

  logic [H_BITS-1:0] cycle_q, cycle_d, cyc_nxt;
  logic [V_BITS-1:0] scanline_q, scanline_d, line_nxt;
  logic [H_BITS-1:0] fetch_cycle_q, fetch_cycle_d, fcyc_nxt;
  logic [V_BITS-1:0] fetch_scanline_q, fetch_scanline_d, fline_nxt;
  logic              vga_hs_q, vga_hs_d;
  logic              vga_vs_q, vga_vs_d;
  logic              vga_blank_q, vga_blank_d;
  logic              fetch_active_q, fetch_active_d;
  logic              line_start_q, line_start_d;
  logic              frame_start_q, frame_start_d;
  logic [7:0]        frame_count_q, frame_count_d;
  logic              vblank_irq_q, vblank_irq_d;
  logic              irq_set;

  // Raster-order successor of the current and the fetch position.
  always_comb begin
    if (cycle_q == HLast) begin
      cyc_nxt  = '0;
      line_nxt = (scanline_q == VLast) ? '0 : scanline_q + V_BITS'(1);
    end else begin
      cyc_nxt  = cycle_q + H_BITS'(1);
      line_nxt = scanline_q;
    end
    if (fetch_cycle_q == HLast) begin
      fcyc_nxt  = '0;
      fline_nxt = (fetch_scanline_q == VLast) ? '0 : fetch_scanline_q + V_BITS'(1);
    end else begin
      fcyc_nxt  = fetch_cycle_q + H_BITS'(1);
      fline_nxt = fetch_scanline_q;
    end
  end

  always_comb begin
    cycle_d          = cycle_q;
    scanline_d       = scanline_q;
    fetch_cycle_d    = fetch_cycle_q;
    fetch_scanline_d = fetch_scanline_q;
    vga_hs_d         = vga_hs_q;
    vga_vs_d         = vga_vs_q;
    vga_blank_d      = vga_blank_q;
    fetch_active_d   = fetch_active_q;
    line_start_d     = 1'b0;
    frame_start_d    = 1'b0;
    frame_count_d    = frame_count_q;
    irq_set          = 1'b0;
    if (enable) begin
      cycle_d          = cyc_nxt;
      scanline_d       = line_nxt;
      fetch_cycle_d    = fcyc_nxt;
      fetch_scanline_d = fline_nxt;
      vga_hs_d         = (cyc_nxt >= HSyncFirst && cyc_nxt <= HSyncLast) ? HS_POL : ~HS_POL;
      vga_vs_d         = (line_nxt >= VSyncFirst && line_nxt <= VSyncLast) ? VS_POL : ~VS_POL;
      vga_blank_d      = (cyc_nxt >= HActive) || (line_nxt >= VActive);
      fetch_active_d   = (fcyc_nxt < HActive) && (fline_nxt < VActive);
      line_start_d     = (cyc_nxt == '0);
      frame_start_d    = (cyc_nxt == '0) && (line_nxt == '0);
      frame_count_d    = frame_start_d ? frame_count_q + 8'd1 : frame_count_q;
      irq_set          = (cyc_nxt == '0) && (line_nxt == VActive);
    end
    // A new vblank event beats an acknowledge arriving on the same clock.
    vblank_irq_d = irq_set | (vblank_irq_q & ~irq_ack);
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      cycle_q          <= '0;
      scanline_q       <= '0;
      fetch_cycle_q    <= FetchRstCycle;
      fetch_scanline_q <= '0;
      vga_hs_q         <= ~HS_POL;
      vga_vs_q         <= ~VS_POL;
      vga_blank_q      <= 1'b0;
      fetch_active_q   <= FetchRstActive;
      line_start_q     <= 1'b0;
      frame_start_q    <= 1'b0;
      frame_count_q    <= 8'd0;
      vblank_irq_q     <= 1'b0;
    end else begin
      cycle_q          <= cycle_d;
      scanline_q       <= scanline_d;
      fetch_cycle_q    <= fetch_cycle_d;
      fetch_scanline_q <= fetch_scanline_d;
      vga_hs_q         <= vga_hs_d;
      vga_vs_q         <= vga_vs_d;
      vga_blank_q      <= vga_blank_d;
      fetch_active_q   <= fetch_active_d;
      line_start_q     <= line_start_d;
      frame_start_q    <= frame_start_d;
      frame_count_q    <= frame_count_d;
      vblank_irq_q     <= vblank_irq_d;
    end
  end

  assign cycle          = cycle_q;
  assign scanline       = scanline_q;
  assign fetch_cycle    = fetch_cycle_q;
  assign fetch_scanline = fetch_scanline_q;
  assign vga_hs         = vga_hs_q;
  assign vga_vs         = vga_vs_q;
  assign vga_blank      = vga_blank_q;
  assign fetch_active   = fetch_active_q;
  assign line_start     = line_start_q;
  assign frame_start    = frame_start_q;
  assign frame_count    = frame_count_q;
  assign vblank_irq     = vblank_irq_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: default, mid-size and tiny timing sets, each against a
// position-count reference model through an expected-value queue.
module tb_vga_timing_generator;

  typedef struct packed {
    logic [15:0] c;
    logic [15:0] l;
    logic [15:0] fc;
    logic [15:0] fl;
    logic        fa;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [7:0]  fcnt;
    logic        irq;
  } snap_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  snap_t sb[$];
  int    checks = 0;
  int    passes = 0;

  // Default timing instance.
  logic       d_rst = 1'b1, d_en = 1'b0, d_ack = 1'b0;
  logic [9:0] d_cyc, d_line, d_fc, d_fl;
  logic       d_hs, d_vs, d_blank, d_fa, d_ls, d_fs, d_irq;
  logic [7:0] d_fcnt;

  vga_timing_generator u_def (
    .pixel_clk(clk), .rst(d_rst), .enable(d_en), .irq_ack(d_ack),
    .cycle(d_cyc), .scanline(d_line), .vga_hs(d_hs), .vga_vs(d_vs), .vga_blank(d_blank),
    .fetch_cycle(d_fc), .fetch_scanline(d_fl), .fetch_active(d_fa),
    .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fcnt), .vblank_irq(d_irq)
  );

  // Mid-size timing: 80 clocks x 55 lines, vblank at line 48, vsync lines 50-51.
  logic       m_rst = 1'b1, m_en = 1'b0, m_ack = 1'b0;
  logic [6:0] m_cyc, m_fc;
  logic [5:0] m_line, m_fl;
  logic       m_hs, m_vs, m_blank, m_fa, m_ls, m_fs, m_irq;
  logic [7:0] m_fcnt;

  vga_timing_generator #(
    .H_ACTIVE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_ACTIVE(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .HS_POL(1'b0), .VS_POL(1'b0), .PREFETCH(2), .H_BITS(7), .V_BITS(6)
  ) u_mid (
    .pixel_clk(clk), .rst(m_rst), .enable(m_en), .irq_ack(m_ack),
    .cycle(m_cyc), .scanline(m_line), .vga_hs(m_hs), .vga_vs(m_vs), .vga_blank(m_blank),
    .fetch_cycle(m_fc), .fetch_scanline(m_fl), .fetch_active(m_fa),
    .line_start(m_ls), .frame_start(m_fs), .frame_count(m_fcnt), .vblank_irq(m_irq)
  );

  // Tiny timing: 7 clocks x 6 lines, positive syncs, no look-ahead.
  logic       s_rst = 1'b1, s_en = 1'b0, s_ack = 1'b0;
  logic [2:0] s_cyc, s_line, s_fc, s_fl;
  logic       s_hs, s_vs, s_blank, s_fa, s_ls, s_fs, s_irq;
  logic [7:0] s_fcnt;

  vga_timing_generator #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PREFETCH(0), .H_BITS(3), .V_BITS(3)
  ) u_sml (
    .pixel_clk(clk), .rst(s_rst), .enable(s_en), .irq_ack(s_ack),
    .cycle(s_cyc), .scanline(s_line), .vga_hs(s_hs), .vga_vs(s_vs), .vga_blank(s_blank),
    .fetch_cycle(s_fc), .fetch_scanline(s_fl), .fetch_active(s_fa),
    .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fcnt), .vblank_irq(s_irq)
  );

  // Expected outputs after n advancing clocks since reset; adv = last edge advanced.
  function automatic snap_t ref_snap(input int ha, input int hf, input int hsy, input int hb,
                                     input int va, input int vf, input int vsy, input int vb,
                                     input bit hp, input bit vp, input int pf,
                                     input longint n, input bit adv, input bit irq);
    snap_t  s;
    int     ht, vt, c, l, fc, fl;
    longint fn;
    ht = ha + hf + hsy + hb;
    vt = va + vf + vsy + vb;
    c  = int'(n % longint'(ht));
    l  = int'((n / longint'(ht)) % longint'(vt));
    fn = n + longint'(pf);
    fc = int'(fn % longint'(ht));
    fl = int'((fn / longint'(ht)) % longint'(vt));
    s.c     = 16'(c);
    s.l     = 16'(l);
    s.fc    = 16'(fc);
    s.fl    = 16'(fl);
    s.fa    = (fc < ha) && (fl < va);
    s.blank = (c >= ha) || (l >= va);
    s.hs    = (c >= ha + hf && c < ha + hf + hsy) ? hp : !hp;
    s.vs    = (l >= va + vf && l < va + vf + vsy) ? vp : !vp;
    s.ls    = adv && (c == 0);
    s.fs    = adv && (c == 0) && (l == 0);
    s.fcnt  = 8'((n / longint'(ht * vt)) % 256);
    s.irq   = irq;
    return s;
  endfunction

  function automatic snap_t exp_def(input longint n, input bit adv, input bit irq);
    return ref_snap(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2, n, adv, irq);
  endfunction

  function automatic snap_t exp_mid(input longint n, input bit adv, input bit irq);
    return ref_snap(64, 4, 8, 4, 48, 2, 2, 3, 1'b0, 1'b0, 2, n, adv, irq);
  endfunction

  function automatic snap_t exp_sml(input longint n, input bit adv, input bit irq);
    return ref_snap(4, 1, 1, 1, 3, 1, 1, 1, 1'b1, 1'b1, 0, n, adv, irq);
  endfunction

  function automatic snap_t act_def();
    return '{c: 16'(d_cyc), l: 16'(d_line), fc: 16'(d_fc), fl: 16'(d_fl), fa: d_fa,
             blank: d_blank, hs: d_hs, vs: d_vs, ls: d_ls, fs: d_fs, fcnt: d_fcnt, irq: d_irq};
  endfunction

  function automatic snap_t act_mid();
    return '{c: 16'(m_cyc), l: 16'(m_line), fc: 16'(m_fc), fl: 16'(m_fl), fa: m_fa,
             blank: m_blank, hs: m_hs, vs: m_vs, ls: m_ls, fs: m_fs, fcnt: m_fcnt, irq: m_irq};
  endfunction

  function automatic snap_t act_sml();
    return '{c: 16'(s_cyc), l: 16'(s_line), fc: 16'(s_fc), fl: 16'(s_fl), fa: s_fa,
             blank: s_blank, hs: s_hs, vs: s_vs, ls: s_ls, fs: s_fs, fcnt: s_fcnt, irq: s_irq};
  endfunction

  task automatic test_reset();
    snap_t e, a;
    d_rst = 1'b1; d_en = 1'b1; d_ack = 1'b1;
    sb.push_back(exp_def(0, 1'b0, 1'b0));
    @(posedge clk); #1;
    e = sb.pop_front(); a = act_def(); checks++;
    if (a !== e) $display("FAIL reset_state actual=%h required=%h", a, e);
    else passes++;
    d_rst = 1'b0; d_ack = 1'b0;
    repeat (2 * 800 + 300) begin @(posedge clk); #1; end
    checks++;
    if (d_cyc !== 10'd300 || d_line !== 10'd2)
      $display("FAIL pre_reset_pos actual=(%0d,%0d) required=(300,2)", d_cyc, d_line);
    else passes++;
    d_rst = 1'b1; d_ack = 1'b1;
    sb.push_back(exp_def(0, 1'b0, 1'b0));
    @(posedge clk); #1;
    e = sb.pop_front(); a = act_def(); checks++;
    if (a !== e) $display("FAIL mid_frame_reset actual=%h required=%h", a, e);
    else passes++;
    d_rst = 1'b0; d_ack = 1'b0;
    sb.push_back(exp_def(1, 1'b1, 1'b0));
    @(posedge clk); #1;
    e = sb.pop_front(); a = act_def(); checks++;
    if (a !== e) $display("FAIL first_advance actual=%h required=%h", a, e);
    else passes++;
  endtask

  task automatic test_raster_default();
    snap_t  e, a;
    longint n;
    int     hs_lo, hs_first, hs_last, blank_first;
    hs_lo = 0; hs_first = -1; hs_last = -1; blank_first = -1;
    d_rst = 1'b1; @(posedge clk); #1;
    d_rst = 1'b0; d_en = 1'b1; n = 0;
    for (int k = 0; k < 8800; k++) begin
      n++;
      sb.push_back(exp_def(n, 1'b1, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); a = act_def(); checks++;
      if (a !== e) $display("FAIL raster_default n=%0d actual=%h required=%h", n, a, e);
      else passes++;
      if (n / 800 == 3 && d_hs == 1'b0) begin
        hs_lo++;
        if (hs_first < 0) hs_first = int'(d_cyc);
        hs_last = int'(d_cyc);
      end
      if (n < 800 && d_blank && blank_first < 0) blank_first = int'(d_cyc);
      if (n == 8798) begin
        checks++;
        if (d_fc !== 10'd0 || d_fl !== 10'd11)
          $display("FAIL fetch_line_wrap actual=(%0d,%0d) required=(0,11)", d_fc, d_fl);
        else passes++;
      end
      if (n == 8638) begin
        checks++;
        if (d_fc !== 10'd640 || d_fl !== 10'd10 || d_fa !== 1'b0)
          $display("FAIL fetch_into_blank actual=(%0d,%0d,%b) required=(640,10,0)",
                   d_fc, d_fl, d_fa);
        else passes++;
      end
    end
    checks++;
    if (hs_lo != 96 || hs_first != 656 || hs_last != 751)
      $display("FAIL hsync_window actual=%0d clocks %0d..%0d required=96 clocks 656..751",
               hs_lo, hs_first, hs_last);
    else passes++;
    checks++;
    if (blank_first != 640)
      $display("FAIL hblank_start actual=%0d required=640", blank_first);
    else passes++;
    d_en = 1'b0;
  endtask

  task automatic test_vblank_irq();
    snap_t  e, a;
    longint n;
    bit     irq, enter;
    int     vs_lo;
    vs_lo = 0; irq = 1'b0;
    m_rst = 1'b1; @(posedge clk); #1;
    m_rst = 1'b0; m_en = 1'b1; n = 0;
    for (int k = 0; k < 12700; k++) begin
      n++;
      m_ack = (n == 3840 || n == 3841);
      enter = (n % 80 == 0) && ((n / 80) % 55 == 48);
      irq   = enter ? 1'b1 : (m_ack ? 1'b0 : irq);
      sb.push_back(exp_mid(n, 1'b1, irq));
      @(posedge clk); #1;
      e = sb.pop_front(); a = act_mid(); checks++;
      if (a !== e) $display("FAIL raster_mid n=%0d actual=%h required=%h", n, a, e);
      else passes++;
      if (n <= 4400 && m_vs == 1'b0) vs_lo++;
      if (n == 3840 || n == 3841 || n == 8239 || n == 8240 || n == 12600) begin
        checks++;
        if (m_irq !== (n == 3840 || n == 8240 || n == 12600))
          $display("FAIL vblank_irq n=%0d actual=%b required=%b", n, m_irq,
                   (n == 3840 || n == 8240 || n == 12600));
        else passes++;
      end
      if (n == 4399) begin
        checks++;
        if (m_fc !== 7'd1 || m_fl !== 6'd0 || m_fa !== 1'b1)
          $display("FAIL fetch_frame_wrap actual=(%0d,%0d,%b) required=(1,0,1)",
                   m_fc, m_fl, m_fa);
        else passes++;
      end
    end
    checks++;
    if (vs_lo != 160) $display("FAIL vsync_clocks actual=%0d required=160", vs_lo);
    else passes++;
    m_ack = 1'b0;
  endtask

  task automatic test_enable_freeze();
    snap_t  e, a;
    longint n;
    bit     irq, en, enter;
    irq = 1'b0;
    m_rst = 1'b1; @(posedge clk); #1;
    m_rst = 1'b0; n = 0;
    for (int k = 0; k < 4120; k++) begin
      en    = !((k >= 3839 && k <= 3843) || (k >= 4100 && k <= 4102));
      m_en  = en;
      m_ack = (k == 4100);
      if (en) n++;
      enter = en && (n % 80 == 0) && ((n / 80) % 55 == 48);
      irq   = enter ? 1'b1 : (m_ack ? 1'b0 : irq);
      sb.push_back(exp_mid(n, en, irq));
      @(posedge clk); #1;
      e = sb.pop_front(); a = act_mid(); checks++;
      if (a !== e) $display("FAIL freeze_mid k=%0d actual=%h required=%h", k, a, e);
      else passes++;
      if (k == 3843) begin
        checks++;
        if (m_cyc !== 7'd79 || m_line !== 6'd47 || m_ls !== 1'b0)
          $display("FAIL frozen_pos actual=(%0d,%0d,%b) required=(79,47,0)",
                   m_cyc, m_line, m_ls);
        else passes++;
      end
      if (k == 3844) begin
        checks++;
        if (m_cyc !== 7'd0 || m_line !== 6'd48 || m_ls !== 1'b1 || m_irq !== 1'b1)
          $display("FAIL resume_vblank actual=(%0d,%0d,%b,%b) required=(0,48,1,1)",
                   m_cyc, m_line, m_ls, m_irq);
        else passes++;
      end
      if (k == 4100) begin
        checks++;
        if (m_irq !== 1'b0) $display("FAIL ack_while_frozen actual=%b required=0", m_irq);
        else passes++;
      end
    end
    m_en = 1'b0; m_ack = 1'b0;
  endtask

  task automatic test_small_wrap();
    snap_t  e, a;
    longint n;
    bit     irq;
    int     hs_hi, vs_hi;
    hs_hi = 0; vs_hi = 0; irq = 1'b0;
    s_rst = 1'b1; @(posedge clk); #1;
    s_rst = 1'b0; s_en = 1'b1; n = 0;
    for (int k = 0; k < 256 * 42 + 3; k++) begin
      n++;
      if ((n % 7 == 0) && ((n / 7) % 6 == 3)) irq = 1'b1;
      sb.push_back(exp_sml(n, 1'b1, irq));
      @(posedge clk); #1;
      e = sb.pop_front(); a = act_sml(); checks++;
      if (a !== e) $display("FAIL raster_small n=%0d actual=%h required=%h", n, a, e);
      else passes++;
      if (n <= 42) begin
        if (s_hs == 1'b1) hs_hi++;
        if (s_vs == 1'b1) vs_hi++;
      end
      if (n == 255 * 42) begin
        checks++;
        if (s_fcnt !== 8'd255) $display("FAIL frame_count_255 actual=%0d required=255", s_fcnt);
        else passes++;
      end
      if (n == 256 * 42) begin
        checks++;
        if (s_fcnt !== 8'd0 || s_fs !== 1'b1)
          $display("FAIL frame_count_wrap actual=(%0d,%b) required=(0,1)", s_fcnt, s_fs);
        else passes++;
      end
    end
    checks++;
    if (hs_hi != 6 || vs_hi != 7)
      $display("FAIL small_sync_clocks actual=(%0d,%0d) required=(6,7)", hs_hi, vs_hi);
    else passes++;
    s_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_raster_default();
    test_vblank_irq();
    test_enable_freeze();
    test_small_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
